// File: rtl/alu_ctl_sequencer.sv
// Sequences ALU block control lines from 8-bit instructions: accept, operand setup, single exec cycle, done.
// All outputs are registered; operands and carry are captured at accept so instr/fout may change afterwards.
//
// state | meaning
// IDLE  | ready for an instruction; NOP/illegal complete here without touching the ALU
// SETUP | operands, alt and cin driven; bus and load idle while the down-counter runs
// EXEC  | one cycle of bus transfer, register load and optional flag calculate
module alu_ctl_sequencer #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned CARRY_BIT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic [3:0] fout,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic [1:0] arg_l,
  output logic [2:0] arg_r,
  output logic       alt,
  output logic       calcfn,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EXEC
  } state_t;

  localparam logic [3:0] SETUP_INIT = 4'(SETUP_CYCLES);
  localparam logic [3:0] SEL_NONE   = 4'hF;

  state_t     state;
  logic [3:0] setup_cnt;
  logic [3:0] exec_out;
  logic [3:0] exec_load;
  logic       exec_calc;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       carry;
  logic [1:0] d_l;
  logic [2:0] d_r;
  logic       d_alt;
  logic       d_cin;
  logic [3:0] d_out;
  logic [3:0] d_load;
  logic       d_calc;
  logic       accept;
  logic       no_alu_op;

  assign op        = instr[7:4];
  assign rd        = instr[3:2];
  assign rs        = instr[1:0];
  assign carry     = fout[CARRY_BIT];
  assign accept    = instr_valid && instr_ready;
  assign no_alu_op = (op == 4'hE) || (op == 4'hF);

  // Instruction decode into the ALU control fields that will be latched at accept.
  always_comb begin
    d_l    = rd;
    d_r    = {1'b0, rs};
    d_alt  = 1'b0;
    d_cin  = 1'b0;
    d_out  = SEL_NONE;
    d_load = {2'b00, rd};
    d_calc = 1'b0;
    case (op)
      4'h0: begin
        d_l   = 2'd0;
        d_r   = 3'd0;
        d_out = {2'b00, rs};
      end
      4'h1: begin
        d_out  = 4'h5;
        d_calc = 1'b1;
      end
      4'h2: begin
        d_out  = 4'h5;
        d_cin  = carry;
        d_calc = 1'b1;
      end
      4'h3: begin
        d_out  = 4'h5;
        d_alt  = 1'b1;
        d_cin  = 1'b1;
        d_calc = 1'b1;
      end
      4'h4: begin
        d_out  = 4'h5;
        d_alt  = 1'b1;
        d_cin  = carry;
        d_calc = 1'b1;
      end
      4'h5: d_out = 4'h6;
      4'h6: begin
        d_out = 4'h6;
        d_alt = 1'b1;
      end
      4'h7: d_out = 4'hA;
      4'h8: begin
        d_out = 4'hA;
        d_alt = 1'b1;
      end
      4'h9: begin
        d_r    = 3'd0;
        d_out  = 4'h7;
        d_calc = 1'b1;
      end
      4'hA: begin
        d_r    = 3'd0;
        d_out  = 4'h7;
        d_cin  = carry;
        d_calc = 1'b1;
      end
      4'hB: begin
        d_r   = 3'd0;
        d_out = 4'h7;
        d_alt = 1'b1;
      end
      4'hC: begin
        d_r   = 3'd6;
        d_out = 4'h6;
      end
      4'hD: begin
        d_out  = 4'h5;
        d_load = SEL_NONE;
        d_alt  = 1'b1;
        d_cin  = 1'b1;
        d_calc = 1'b1;
      end
      default: begin
        d_l    = 2'd0;
        d_r    = 3'd0;
        d_load = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      setup_cnt   <= 4'd0;
      exec_out    <= SEL_NONE;
      exec_load   <= SEL_NONE;
      exec_calc   <= 1'b0;
      outctl      <= SEL_NONE;
      loadctl     <= SEL_NONE;
      arg_l       <= 2'd0;
      arg_r       <= 3'd0;
      alt         <= 1'b0;
      calcfn      <= 1'b1;
      cin         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (no_alu_op) begin
              done    <= 1'b1;
              illegal <= (op == 4'hF);
            end else begin
              state       <= ST_SETUP;
              setup_cnt   <= SETUP_INIT;
              arg_l       <= d_l;
              arg_r       <= d_r;
              alt         <= d_alt;
              cin         <= d_cin;
              exec_out    <= d_out;
              exec_load   <= d_load;
              exec_calc   <= d_calc;
              busy        <= 1'b1;
              instr_ready <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          setup_cnt <= setup_cnt - 4'd1;
          // terminal count: this decrement brings the counter to zero
          if (setup_cnt == 4'd1) begin
            state   <= ST_EXEC;
            outctl  <= exec_out;
            loadctl <= exec_load;
            calcfn  <= ~exec_calc;
          end
        end
        ST_EXEC: begin
          state       <= ST_IDLE;
          outctl      <= SEL_NONE;
          loadctl     <= SEL_NONE;
          calcfn      <= 1'b1;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          done        <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          outctl      <= SEL_NONE;
          loadctl     <= SEL_NONE;
          calcfn      <= 1'b1;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctl_sequencer.sv
// Directed bench for alu_ctl_sequencer: vector table through a SETUP_CYCLES=1 instance,
// plus hand sequences for NOP/illegal, long setup with held valid, carry capture and reset in EXEC.
module tb_alu_ctl_sequencer;

  logic       clk = 1'b0;
  logic       rst;

  logic       instr_valid, instr_ready;
  logic [7:0] instr;
  logic [3:0] fout, outctl, loadctl;
  logic [1:0] arg_l;
  logic [2:0] arg_r;
  logic       alt, calcfn, cin, busy, done, illegal;

  logic       instr_valid3, instr_ready3;
  logic [7:0] instr3;
  logic [3:0] fout3, outctl3, loadctl3;
  logic [1:0] arg_l3;
  logic [2:0] arg_r3;
  logic       alt3, calcfn3, cin3, busy3, done3, illegal3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_ctl_sequencer #(.SETUP_CYCLES(1), .CARRY_BIT(1)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .fout(fout), .outctl(outctl), .loadctl(loadctl),
    .arg_l(arg_l), .arg_r(arg_r), .alt(alt), .calcfn(calcfn), .cin(cin),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_ctl_sequencer #(.SETUP_CYCLES(3), .CARRY_BIT(1)) u_dut3 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
    .instr(instr3), .fout(fout3), .outctl(outctl3), .loadctl(loadctl3),
    .arg_l(arg_l3), .arg_r(arg_r3), .alt(alt3), .calcfn(calcfn3), .cin(cin3),
    .busy(busy3), .done(done3), .illegal(illegal3)
  );

  typedef struct {
    logic [7:0] instr;
    logic [3:0] fout;
    logic [1:0] l;
    logic [2:0] r;
    logic       alt;
    logic       cin;
    logic [3:0] out;
    logic [3:0] load;
    logic       calcfn;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    instr       = v.instr;
    fout        = v.fout;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 8'hFF;
    fout        = ~v.fout;
    chk($sformatf("setup_busy %h", v.instr), busy, 1'b1);
    chk($sformatf("setup_ready %h", v.instr), instr_ready, 1'b0);
    chk($sformatf("setup_arg_l %h", v.instr), arg_l, v.l);
    chk($sformatf("setup_arg_r %h", v.instr), arg_r, v.r);
    chk($sformatf("setup_alt %h", v.instr), alt, v.alt);
    chk($sformatf("setup_cin %h", v.instr), cin, v.cin);
    chk($sformatf("setup_outctl %h", v.instr), outctl, 4'hF);
    chk($sformatf("setup_loadctl %h", v.instr), loadctl, 4'hF);
    chk($sformatf("setup_calcfn %h", v.instr), calcfn, 1'b1);
    @(negedge clk);
    chk($sformatf("exec_outctl %h", v.instr), outctl, v.out);
    chk($sformatf("exec_loadctl %h", v.instr), loadctl, v.load);
    chk($sformatf("exec_calcfn %h", v.instr), calcfn, v.calcfn);
    chk($sformatf("exec_arg_l %h", v.instr), arg_l, v.l);
    chk($sformatf("exec_arg_r %h", v.instr), arg_r, v.r);
    chk($sformatf("exec_cin %h", v.instr), cin, v.cin);
    chk($sformatf("exec_done %h", v.instr), done, 1'b0);
    @(negedge clk);
    chk($sformatf("done_pulse %h", v.instr), done, 1'b1);
    chk($sformatf("done_illegal %h", v.instr), illegal, 1'b0);
    chk($sformatf("done_outctl %h", v.instr), outctl, 4'hF);
    chk($sformatf("done_loadctl %h", v.instr), loadctl, 4'hF);
    chk($sformatf("done_calcfn %h", v.instr), calcfn, 1'b1);
    chk($sformatf("done_busy %h", v.instr), busy, 1'b0);
    chk($sformatf("done_ready %h", v.instr), instr_ready, 1'b1);
    @(negedge clk);
    chk($sformatf("done_clear %h", v.instr), done, 1'b0);
  endtask

  initial begin
    //            instr  fout   L     R     alt   cin   out    load   calcfn
    vecs[0]  = '{8'h16, 4'h0, 2'd1, 3'd2, 1'b0, 1'b0, 4'h5, 4'h1, 1'b0};
    vecs[1]  = '{8'h4E, 4'h0, 2'd3, 3'd2, 1'b1, 1'b0, 4'h5, 4'h3, 1'b0};
    vecs[2]  = '{8'hD1, 4'h0, 2'd0, 3'd1, 1'b1, 1'b1, 4'h5, 4'hF, 1'b0};
    vecs[3]  = '{8'hC8, 4'h0, 2'd2, 3'd6, 1'b0, 1'b0, 4'h6, 4'h2, 1'b1};
    vecs[4]  = '{8'h0B, 4'h2, 2'd0, 3'd0, 1'b0, 1'b0, 4'h3, 4'h2, 1'b1};
    vecs[5]  = '{8'h2F, 4'h2, 2'd3, 3'd3, 1'b0, 1'b1, 4'h5, 4'h3, 1'b0};
    vecs[6]  = '{8'h65, 4'h0, 2'd1, 3'd1, 1'b1, 1'b0, 4'h6, 4'h1, 1'b1};
    vecs[7]  = '{8'h83, 4'h0, 2'd0, 3'd3, 1'b1, 1'b0, 4'hA, 4'h0, 1'b1};
    vecs[8]  = '{8'hA6, 4'h2, 2'd1, 3'd0, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0};
    vecs[9]  = '{8'hBB, 4'h2, 2'd2, 3'd0, 1'b1, 1'b0, 4'h7, 4'h2, 1'b1};
    vecs[10] = '{8'h3C, 4'h0, 2'd3, 3'd0, 1'b1, 1'b1, 4'h5, 4'h3, 1'b0};
    vecs[11] = '{8'h55, 4'h0, 2'd1, 3'd1, 1'b0, 1'b0, 4'h6, 4'h1, 1'b1};
    vecs[12] = '{8'h74, 4'h0, 2'd1, 3'd0, 1'b0, 1'b0, 4'hA, 4'h1, 1'b1};
    vecs[13] = '{8'h9D, 4'h2, 2'd3, 3'd0, 1'b0, 1'b0, 4'h7, 4'h3, 1'b0};

    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr        = 8'h00;
    fout         = 4'h0;
    instr_valid3 = 1'b0;
    instr3       = 8'h00;
    fout3        = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outctl", outctl, 4'hF);
    chk("rst_loadctl", loadctl, 4'hF);
    chk("rst_arg_l", arg_l, 2'd0);
    chk("rst_arg_r", arg_r, 3'd0);
    chk("rst_alt", alt, 1'b0);
    chk("rst_calcfn", calcfn, 1'b1);
    chk("rst_cin", cin, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // SBC with carry clear at accept, flags toggling afterwards
    instr = 8'h4E; fout = 4'h0; instr_valid = 1'b1;
    @(posedge clk);
    #1 fout = 4'hF; instr = 8'h00;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("sbc_setup_cin", cin, 1'b0);
    chk("sbc_setup_alt", alt, 1'b1);
    fout = 4'h0;
    #2 fout = 4'h2;
    @(negedge clk);
    chk("sbc_exec_cin", cin, 1'b0);
    chk("sbc_exec_alt", alt, 1'b1);
    chk("sbc_exec_outctl", outctl, 4'h5);
    @(negedge clk);
    chk("sbc_done", done, 1'b1);
    @(negedge clk);

    // illegal then NOP back-to-back, never busy
    instr = 8'hF0; instr_valid = 1'b1;
    @(negedge clk);
    chk("f0_done", done, 1'b1);
    chk("f0_illegal", illegal, 1'b1);
    chk("f0_busy", busy, 1'b0);
    chk("f0_ready", instr_ready, 1'b1);
    chk("f0_outctl", outctl, 4'hF);
    instr = 8'hE0;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("e0_done", done, 1'b1);
    chk("e0_illegal", illegal, 1'b0);
    chk("e0_busy", busy, 1'b0);
    @(negedge clk);
    chk("e0_done_clear", done, 1'b0);
    chk("e0_busy_after", busy, 1'b0);

    // SETUP_CYCLES=3, MOV C,A with valid held high throughout
    instr3 = 8'h08; fout3 = 4'h0; instr_valid3 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        chk($sformatf("mov3_setup_busy c%0d", c), busy3, 1'b1);
        chk($sformatf("mov3_setup_outctl c%0d", c), outctl3, 4'hF);
        chk($sformatf("mov3_setup_ready c%0d", c), instr_ready3, 1'b0);
      end else if (c == 4) begin
        chk("mov3_exec_outctl", outctl3, 4'h0);
        chk("mov3_exec_loadctl", loadctl3, 4'h2);
        chk("mov3_exec_calcfn", calcfn3, 1'b1);
        chk("mov3_exec_arg_l", arg_l3, 2'd0);
      end else if (c == 5) begin
        chk("mov3_done", done3, 1'b1);
        chk("mov3_done_ready", instr_ready3, 1'b1);
        chk("mov3_done_outctl", outctl3, 4'hF);
        chk("mov3_done_loadctl", loadctl3, 4'hF);
      end else begin
        chk("mov3_reaccept_busy", busy3, 1'b1);
        chk("mov3_reaccept_done", done3, 1'b0);
      end
    end
    instr_valid3 = 1'b0;
    begin
      int budget;
      budget = 0;
      while (done3 !== 1'b1 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("mov3_second_done", done3, 1'b1);
      chk("mov3_second_latency", 8'(budget), 8'd4);
    end
    @(negedge clk);

    // reset during EXEC of ADD B,C
    instr = 8'h16; fout = 4'h0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rexec_outctl_pre", outctl, 4'h5);
    chk("rexec_calcfn_pre", calcfn, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rexec_outctl", outctl, 4'hF);
    chk("rexec_loadctl", loadctl, 4'hF);
    chk("rexec_calcfn", calcfn, 1'b1);
    chk("rexec_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rexec_no_done c%0d", c), done, 1'b0);
      chk($sformatf("rexec_no_load c%0d", c), loadctl, 4'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
